fft_latency_bcd: RTL and testbench
==================================

# fft_latency_bcd

Measures the latency of one FFT run, from the `en_FFT` start strobe to the `done_FFT` completion strobe, in ticks of `PRESCALE` clocks. It converts the saturated tick count to packed BCD with a sequential double-dabble engine and presents the digits with a one-cycle valid strobe. It sits between the FFT core's control strobes and the 7-segment display stage, which consumes `bcd` on `bcd_valid` and only multiplexes digits.

## Interface
- `PRESCALE`, 100: clocks per tick; must be ≥ 2.
- `DIGITS`, 4: BCD digits produced.
- `CNT_W`, 14: tick counter width; must hold 10^DIGITS − 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-high.
- `en_FFT`  in  1  FFT start strobe, sampled each edge.
- `done_FFT`  in  1  FFT completion strobe, sampled each edge.
- `busy`  out  1  high whenever the state is not IDLE (registered).
- `bcd`  out  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]; held between updates.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` and `overflow` update.
- `overflow`  out  1  the tick count saturated during the run that produced `bcd`.

## Operation
- States: IDLE, MEASURE, CONVERT, DONE.
- **IDLE:**
  - `en_FFT` = 1 moves to MEASURE and clears `pre`, `ticks` and `sat`.
  - `done_FFT` is ignored.
- **MEASURE:** each edge with `done_FFT` = 0 and `en_FFT` = 0 does the following.
  - If `pre` = PRESCALE−1: `pre` ← 0, and `ticks` ← `ticks` + 1.
  - If `ticks` is already at MAX = 10^DIGITS − 1, it holds at MAX and `sat` ← 1.
  - Otherwise `pre` ← `pre` + 1.
- **MEASURE, `en_FFT` = 1 without `done_FFT`:** restart. Clear `pre`, `ticks` and `sat`; stay in MEASURE.
- **MEASURE, `done_FFT` = 1 (wins over a simultaneous `en_FFT`):**
  - No count on this edge.
  - Load the shift register {4*DIGITS zeros, `ticks`} and clear `iter`.
  - Go to CONVERT.
- **CONVERT:** one double-dabble iteration per edge.
  - Every BCD nibble ≥ 5 gets +3.
  - Then the whole register shifts left by 1 and `iter` increments.
  - After iteration CNT_W−1 (CNT_W edges in CONVERT), go to DONE.
- **DONE:**
  - `bcd` ← the upper 4*DIGITS bits of the shift register.
  - `overflow` ← `sat`; `bcd_valid` ← 1.
  - Go to IDLE.
- `en_FFT` and `done_FFT` are ignored in CONVERT and DONE; a start during conversion is lost.
- **Result:** `ticks` = min(floor(N / PRESCALE), MAX), where N is the number of MEASURE counting edges strictly between acceptance edge S and done edge E, so N = E − S − 1.
- **Widths:**
  - `pre` is ceil(log2(PRESCALE)) bits.
  - The shift register is 4*DIGITS + CNT_W bits.
  - No nibble ever exceeds 9 after a shift.

## Timing
- **Reset values:**
  - State IDLE; `busy` = 0, `bcd` = 0, `bcd_valid` = 0, `overflow` = 0.
  - Internal `pre`, `ticks`, `sat`, `iter` and shift register are all 0.
- **Reset mid-operation:** any state aborts immediately to the reset values; the next `en_FFT` starts a fresh run.
- `busy` rises on edge S and falls on edge E + CNT_W + 2.
- `bcd_valid` is registered high on edge E + CNT_W + 1 and low on the next edge, exactly one cycle (CNT_W + 1 clocks after done).
- `bcd` is stable from edge E + CNT_W + 1 until the next `bcd_valid`.
- Minimum run-to-run spacing: `en_FFT` is accepted at the earliest on edge E + CNT_W + 2.
- Strobes may be single-cycle pulses or levels.
  - A level `en_FFT` held in MEASURE keeps restarting the measurement.
  - The FFT core must pulse `en_FFT`.

## Test plan
- **Reset check:** assert `rst` for 3 cycles → `bcd` = 16'h0000, `bcd_valid` = 0, `overflow` = 0, `busy` = 0; strobes during reset are ignored.
- **Short run:** `en_FFT` pulse at S, `done_FFT` pulse at S+251 → `bcd_valid` at E+15, `bcd` = 16'h0002, `overflow` = 0; `busy` high from S to E+16.
- **Long run:** `done_FFT` at S+123457 → `bcd` = 16'h1234, `overflow` = 0; then a second run with `done_FFT` at S+101 gives `bcd` = 16'h0001.
- **Saturation:** `done_FFT` at S+1_000_101 → `bcd` = 16'h9999, `overflow` = 1; the next normal run clears `overflow` to 0.
- **Strobe collisions:**
  - Re-pulse `en_FFT` at S+150, then `done_FFT` at S+351 → `bcd` = 16'h0002.
  - `en_FFT` and `done_FFT` on the same MEASURE edge → conversion starts.
  - `en_FFT` during CONVERT → ignored, no second `bcd_valid`.
- **Reset mid-CONVERT:** assert `rst` at E+5 → outputs return to 0 and no `bcd_valid` appears; the following run with `done_FFT` at S+501 → `bcd` = 16'h0005.

Source files
------------

// File: rtl/fft_latency_bcd_if.sv
// Control strobes from the FFT core and the BCD result bundle for the
// display stage. The FFT side drives the strobes (master); the latency
// meter drives the result (slave).
interface fft_latency_bcd_if #(
    parameter int DIGITS = 4
);
    logic                  en_FFT;
    logic                  done_FFT;
    logic                  busy;
    logic [4*DIGITS-1:0]   bcd;
    logic                  bcd_valid;
    logic                  overflow;

    modport master (
        output en_FFT,
        output done_FFT,
        input  busy,
        input  bcd,
        input  bcd_valid,
        input  overflow
    );

    modport slave (
        input  en_FFT,
        input  done_FFT,
        output busy,
        output bcd,
        output bcd_valid,
        output overflow
    );
endinterface

// File: rtl/fft_latency_bcd.sv
// FFT run latency meter: counts prescaled ticks between en_FFT and done_FFT,
// saturates at 10^DIGITS-1, and converts the count to packed BCD with a
// sequential double-dabble engine (one iteration per clock).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for en_FFT; done_FFT ignored
// MEASURE | prescaler/tick counter running; en_FFT restarts, done_FFT ends
// CONVERT | CNT_W double-dabble iterations on the shift register
// DONE    | publish bcd/overflow, pulse bcd_valid, return to IDLE
module fft_latency_bcd #(
    parameter int PRESCALE = 100,
    parameter int DIGITS   = 4,
    parameter int CNT_W    = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    fft_latency_bcd_if.slave         bus
);
    localparam int PRE_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + CNT_W;
    localparam int ITER_W = $clog2(CNT_W + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  TICK_MAX  = CNT_W'(10 ** DIGITS - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(CNT_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [PRE_W-1:0]    pre;
    logic [CNT_W-1:0]    ticks;
    logic                sat;
    logic [ITER_W-1:0]   iter;
    logic [SR_W-1:0]     sr;
    logic [SR_W-1:0]     sr_adj;
    logic [SR_W-1:0]     sr_next;

    logic                busy_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                bcd_valid_q;
    logic                overflow_q;

    assign bus.busy      = busy_q;
    assign bus.bcd       = bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.overflow  = overflow_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; done_FFT has priority over en_FFT in MEASURE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.en_FFT) begin
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (bus.done_FFT) begin
                    next_state = CONVERT;
                end
            end
            CONVERT: begin
                if (iter == ITER_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_adj[CNT_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[CNT_W + 4*d +: 4] = sr_adj[CNT_W + 4*d +: 4] + 4'd3;
            end
        end
        sr_next = {sr_adj[SR_W-2:0], 1'b0};
    end

    // Prescaler, saturating tick counter and conversion datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            ticks <= '0;
            sat   <= 1'b0;
            iter  <= '0;
            sr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en_FFT) begin
                        pre   <= '0;
                        ticks <= '0;
                        sat   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (bus.done_FFT) begin
                        sr   <= {{BCD_W{1'b0}}, ticks};
                        iter <= '0;
                    end else if (bus.en_FFT) begin
                        pre   <= '0;
                        ticks <= '0;
                        sat   <= 1'b0;
                    end else if (pre == PRE_LAST) begin
                        pre <= '0;
                        if (ticks == TICK_MAX) begin
                            sat <= 1'b1;
                        end else begin
                            ticks <= ticks + CNT_W'(1);
                        end
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                CONVERT: begin
                    sr   <= sr_next;
                    iter <= iter + ITER_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers; busy stays up through the cycle after DONE so the
    // display stage sees it fall one clock after the valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            busy_q      <= (state != IDLE) || (next_state != IDLE);
            bcd_valid_q <= (state == DONE);
            if (state == DONE) begin
                bcd_q      <= sr[SR_W-1 -: BCD_W];
                overflow_q <= sat;
            end
        end
    end
endmodule

// File: tb/tb_fft_latency_bcd.sv
// Scoreboard bench for fft_latency_bcd. PRESCALE is reduced to 3 so the
// saturation boundary (MAX * PRESCALE clocks) fits in a short run.
// Expected tick count = min(floor((K-1)/3), 9999) where K = E - S.
module tb_fft_latency_bcd;
    localparam int PRESCALE = 3;
    localparam int DIGITS   = 4;
    localparam int CNT_W    = 14;
    localparam int VALID_LAT = CNT_W + 1;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    fft_latency_bcd_if #(.DIGITS(DIGITS)) bus ();

    fft_latency_bcd #(
        .PRESCALE (PRESCALE),
        .DIGITS   (DIGITS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.bcd_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got bcd %h, expected no pulse", bus.bcd);
            end else begin
                e = q.pop_front();
                check("bcd", 32'(bus.bcd), 32'(e.bcd));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
            end
        end
    end

    // One FFT run: start at S, done at S+k. Optional restart at S+restart_at,
    // en_FFT together with done_FFT, or an en_FFT pulse during CONVERT.
    task automatic run(input int k, input logic [15:0] eb, input logic eo,
                       input int restart_at, input bit en_with_done,
                       input bit poke_conv, input bit expect_result);
        exp_t e;
        int   c;
        @(negedge clk);
        bus.en_FFT = 1'b1;
        @(negedge clk);
        bus.en_FFT = 1'b0;
        check("busy_rise", 32'(bus.busy), 32'd1);
        for (int i = 1; i < k; i++) begin
            if (i == restart_at) bus.en_FFT = 1'b1;
            @(negedge clk);
            bus.en_FFT = 1'b0;
        end
        bus.done_FFT = 1'b1;
        bus.en_FFT   = en_with_done;
        if (expect_result) begin
            e.bcd = eb;
            e.ovf = eo;
            q.push_back(e);
        end
        @(negedge clk);
        bus.done_FFT = 1'b0;
        bus.en_FFT   = 1'b0;
        if (!expect_result) return;
        c = 0;
        while (bus.bcd_valid !== 1'b1 && c < 40) begin
            if (poke_conv && c == 4) bus.en_FFT = 1'b1;
            @(negedge clk);
            bus.en_FFT = 1'b0;
            c++;
        end
        check("valid_latency", 32'(c), 32'(VALID_LAT));
        check("busy_hold", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(bus.busy), 32'd0);
        check("valid_one_cycle", 32'(bus.bcd_valid), 32'd0);
        if (poke_conv) begin
            repeat (20) @(negedge clk);
            check("busy_after_poke", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en_FFT   = 1'b1;
        bus.done_FFT = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bus.bcd), 32'h0);
        check("rst_valid", 32'(bus.bcd_valid), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        bus.en_FFT   = 1'b0;
        bus.done_FFT = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 32'(bus.busy), 32'd0);

        run(8,    16'h0002, 1'b0, 0,   1'b0, 1'b0, 1'b1);
        run(3704, 16'h1234, 1'b0, 0,   1'b0, 1'b0, 1'b1);
        run(4,    16'h0001, 1'b0, 0,   1'b0, 1'b0, 1'b1);
        run(1,    16'h0000, 1'b0, 0,   1'b0, 1'b0, 1'b1);
        run(30,   16'h0009, 1'b0, 0,   1'b0, 1'b0, 1'b1);
        run(31,   16'h0010, 1'b0, 0,   1'b0, 1'b0, 1'b1);
        run(2962, 16'h0987, 1'b0, 0,   1'b0, 1'b0, 1'b1);
        run(122,  16'h0007, 1'b0, 100, 1'b0, 1'b0, 1'b1);
        run(10,   16'h0003, 1'b0, 0,   1'b1, 1'b0, 1'b1);
        run(301,  16'h0100, 1'b0, 0,   1'b0, 1'b1, 1'b1);

        // Reset in the middle of CONVERT: no result, outputs cleared.
        run(10, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_bcd", 32'(bus.bcd), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.bcd_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("midrst_idle", 32'(bus.busy), 32'd0);
        run(16, 16'h0005, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        run(30000, 16'h9999, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        run(30001, 16'h9999, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        run(8,     16'h0002, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
